ysyx_22040895_ifu: RTL and testbench
====================================

// Module: ysyx_22040895_ifu
// PURPOSE
//  Instruction fetch unit. Owns the PC, reads 32-bit instructions from the instruction memory
//  port and presents each {inst, pc} pair to the decode stage.
//  Uses a valid/ready handshake, is non-pipelined, and has a one-entry output buffer.
//  Accepts redirects (branch/jal targets) from execute. Any in-flight or buffered fetch is squashed.
// PARAMETERS
//  RESET_PC  64'h0000_0000_8000_0000  PC loaded on reset
//  PC_STEP   4                        sequential PC increment (bytes)
// PORTS
//  clk                    in   1   clock, all state on rising edge
//  rst                    in   1   asynchronous reset, active-low
//  redirect_valid_i_ifu   in   1   redirect request from EXU (single-cycle pulse)
//  redirect_pc_i_ifu      in   64  redirect target
//  imem_req_valid_o_ifu   out  1   fetch request valid
//  imem_req_ready_i_ifu   in   1   memory accepts request
//  imem_req_addr_o_ifu    out  64  fetch address
//  imem_resp_valid_i_ifu  in   1   response valid (exactly one per accepted request)
//  imem_resp_data_i_ifu   in   32  fetched instruction
//  inst_valid_o_ifu       out  1   {inst,pc} valid to IDU
//  inst_ready_i_ifu       in   1   IDU consumes
//  inst_o_ifu             out  32  instruction to IDU
//  pc_o_ifu               out  64  PC of inst_o_ifu
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, pc=RESET_PC, drop=0. All outputs 0 immediately.
//    Exception: imem_req_addr_o_ifu = RESET_PC.
//  FSM states: IDLE, REQ, WAIT, FULL.
//    IDLE -> REQ unconditionally on first clk after rst=1. Responses are ignored in IDLE.
//    REQ : req_valid=1, addr=pc, held stable until req_valid&req_ready. On handshake -> WAIT.
//    WAIT: on resp_valid, if drop=1 clear drop and go -> REQ (response discarded).
//          Otherwise latch inst_o=resp_data, pc_o=pc, and go -> FULL.
//    FULL: inst_valid=1, inst_o/pc_o stable. On inst_ready: pc<=pc+PC_STEP, go -> REQ.
//  Latency: req handshake at cycle N, resp at N+k (k>=1), inst_valid at N+k+1.
//    Next req_valid follows the cycle after the IDU handshake.
//  Redirect (redirect_valid=1), any non-IDLE state; pc<=redirect_pc with bits[1:0] forced 00.
//    REQ without handshake: -> REQ, new address next cycle.
//    REQ with handshake same cycle: drop<=1, -> WAIT.
//    WAIT without resp: drop<=1, stay WAIT. WAIT with resp same cycle: response discarded, -> REQ.
//    FULL: buffered inst discarded, inst_valid=0 next cycle, -> REQ.
//      Redirect beats a coincident inst_ready. The IDU handshake still counts; pc is not stepped.
//    IDLE: pc loaded, -> REQ.
//  Arithmetic: pc+PC_STEP wraps modulo 2^64.
//  Only one request is ever outstanding.
//  resp_valid outside WAIT is a protocol violation: ignored, flagged by assertion.
//  Reset mid-operation: outstanding request forgotten. Memory side must also be reset.
// STRUCTURE
//  Widths and reset polarity come from define.v macros: ysyx_22040895_InstBus,
//    ysyx_22040895_InstAddrBus, ysyx_22040895_RstEnable. Add ysyx_22040895_RstN (1'b0)
//    and the IFU state encodings (2-bit localparams) to define.v.
//  One sub-module: ysyx_22040895_pc_reg (PC register with redirect/step mux and async reset).
//  FSM, drop flag and output buffer live in the top.
// TESTING
//  1 Reset release, req_ready=1, resp 1 cycle later = 32'h00000413 -> first req addr 80000000.
//    inst_valid shows inst 00000413, pc 80000000. After consume, next req addr 80000004.
//  2 inst_ready=0 for 5 cycles in FULL -> inst_o/pc_o constant, req_valid=0 throughout.
//  3 Redirect to 80001000 during WAIT, resp 32'hdeadbeef -> deadbeef never shown.
//    Next req addr 80001000.
//  4 FULL with redirect=1 and inst_ready=1 same cycle, target 80000100 -> next req 80000100.
//    Not old pc+4.
//  5 rst=0 asserted mid-WAIT -> outputs 0 within same cycle; late resp ignored.
//    After release, req addr 80000000.
//  6 Redirect to FFFFFFFFFFFFFFFC, consume -> next req addr 0000000000000000.
//    Redirect to 80000003 -> req addr 80000000.

Source files
------------

// File: rtl/ysyx_22040895_ifu_pkg.sv
// Shared widths, reset level, IFU state encodings and a PC alignment helper.
package ysyx_22040895_ifu_pkg;

  localparam int   INST_W     = 32;   // instruction bus width
  localparam int   ADDR_W     = 64;   // instruction address bus width
  localparam logic RST_ACTIVE = 1'b0; // reset asserted level

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_FULL = 2'd3
  } ifu_state_e;

  // Instructions are word aligned; low two address bits are always cleared.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return pc & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/ysyx_22040895_pc_reg.sv
// Program counter: redirect target has priority over the sequential step.
module ysyx_22040895_pc_reg
  import ysyx_22040895_ifu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              step_en,
  output logic [ADDR_W-1:0] pc
);

  // PC update; the add wraps naturally at 2^64.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      pc <= RESET_PC;
    end else if (redirect_en) begin
      pc <= align_pc(redirect_pc);
    end else if (step_en) begin
      pc <= pc + ADDR_W'(PC_STEP);
    end
  end

endmodule

// File: rtl/ysyx_22040895_ifu.sv
// Instruction fetch unit: non-pipelined, one request outstanding, one-entry output buffer.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IFU_IDLE | just out of reset, nothing issued
// IFU_REQ  | presenting fetch request at pc, waiting for memory accept
// IFU_WAIT | request accepted, waiting for the single response
// IFU_FULL | buffered {inst,pc} offered to decode
module ysyx_22040895_ifu
  import ysyx_22040895_ifu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid_i_ifu,
  input  logic [ADDR_W-1:0] redirect_pc_i_ifu,
  output logic              imem_req_valid_o_ifu,
  input  logic              imem_req_ready_i_ifu,
  output logic [ADDR_W-1:0] imem_req_addr_o_ifu,
  input  logic              imem_resp_valid_i_ifu,
  input  logic [INST_W-1:0] imem_resp_data_i_ifu,
  output logic              inst_valid_o_ifu,
  input  logic              inst_ready_i_ifu,
  output logic [INST_W-1:0] inst_o_ifu,
  output logic [ADDR_W-1:0] pc_o_ifu
);

  ifu_state_e        state_q, state_d;
  logic              drop_q, drop_d;
  logic              pc_step;
  logic              latch_en;
  logic [ADDR_W-1:0] pc;

  ysyx_22040895_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .redirect_en (redirect_valid_i_ifu),
    .redirect_pc (redirect_pc_i_ifu),
    .step_en     (pc_step),
    .pc          (pc)
  );

  assign imem_req_addr_o_ifu = pc;

  // State and drop-flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      state_q <= IFU_IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // Next state, drop flag and handshake outputs. A redirect marks any
  // accepted-but-unanswered request as stale so its response is thrown away.
  always_comb begin
    state_d              = state_q;
    drop_d               = drop_q;
    pc_step              = 1'b0;
    latch_en             = 1'b0;
    imem_req_valid_o_ifu = 1'b0;
    inst_valid_o_ifu     = 1'b0;
    case (state_q)
      IFU_IDLE: begin
        state_d = IFU_REQ;
      end
      IFU_REQ: begin
        imem_req_valid_o_ifu = 1'b1;
        if (imem_req_ready_i_ifu) begin
          state_d = IFU_WAIT;
          if (redirect_valid_i_ifu) drop_d = 1'b1;
        end
      end
      IFU_WAIT: begin
        if (imem_resp_valid_i_ifu) begin
          drop_d = 1'b0;
          if (redirect_valid_i_ifu || drop_q) begin
            state_d = IFU_REQ;
          end else begin
            latch_en = 1'b1;
            state_d  = IFU_FULL;
          end
        end else if (redirect_valid_i_ifu) begin
          drop_d = 1'b1;
        end
      end
      IFU_FULL: begin
        inst_valid_o_ifu = 1'b1;
        // A coincident redirect wins: the buffered instruction is dropped
        // and the PC takes the target instead of stepping.
        if (redirect_valid_i_ifu) begin
          state_d = IFU_REQ;
        end else if (inst_ready_i_ifu) begin
          pc_step = 1'b1;
          state_d = IFU_REQ;
        end
      end
      default: begin
        state_d = IFU_IDLE;
      end
    endcase
  end

  // Output buffer, loaded when a live response arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      inst_o_ifu <= '0;
      pc_o_ifu   <= '0;
    end else if (latch_en) begin
      inst_o_ifu <= imem_resp_data_i_ifu;
      pc_o_ifu   <= pc;
    end
  end

  // Memory may only answer while a request is outstanding.
  resp_only_in_wait: assert property (
    @(posedge clk) disable iff (rst == RST_ACTIVE)
    imem_resp_valid_i_ifu |-> (state_q == IFU_WAIT)
  );

endmodule

// File: tb/tb_ysyx_22040895_ifu.sv
// Bench for the instruction fetch unit: vector table, directed corner sequences, random run.
module tb_ysyx_22040895_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_o;
  logic [63:0] pc_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_22040895_ifu dut (
    .clk                   (clk),
    .rst                   (rst),
    .redirect_valid_i_ifu  (redirect_valid),
    .redirect_pc_i_ifu     (redirect_pc),
    .imem_req_valid_o_ifu  (req_valid),
    .imem_req_ready_i_ifu  (req_ready),
    .imem_req_addr_o_ifu   (req_addr),
    .imem_resp_valid_i_ifu (resp_valid),
    .imem_resp_data_i_ifu  (resp_data),
    .inst_valid_o_ifu      (inst_valid),
    .inst_ready_i_ifu      (inst_ready),
    .inst_o_ifu            (inst_o),
    .pc_o_ifu              (pc_o)
  );

  typedef struct {
    int          k;
    int          stall;
    logic [31:0] data;
    logic [63:0] exp_pc;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Instruction memory contents used by the random run.
  function automatic logic [31:0] mem_fn(input logic [63:0] a);
    return a[31:0] ^ {a[63:48], a[15:0]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [63:0] exp_addr, input string nm);
    int n = 0;
    while (!req_valid && n < 50) begin
      tick();
      n++;
    end
    chk({nm, "_req_valid"}, {63'd0, req_valid}, 64'd1);
    chk({nm, "_req_addr"}, req_addr, exp_addr);
  endtask

  task automatic issue_req(input logic [63:0] exp_addr, input string nm);
    wait_req(exp_addr, nm);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
  endtask

  task automatic give_resp(input int k, input logic [31:0] data);
    repeat (k - 1) tick();
    resp_valid = 1'b1;
    resp_data  = data;
    tick();
    resp_valid = 1'b0;
  endtask

  task automatic check_full(input logic [31:0] exp_inst, input logic [63:0] exp_pc, input string nm);
    chk({nm, "_inst_valid"}, {63'd0, inst_valid}, 64'd1);
    chk({nm, "_inst"}, {32'd0, inst_o}, {32'd0, exp_inst});
    chk({nm, "_pc"}, pc_o, exp_pc);
    chk({nm, "_no_req_in_full"}, {63'd0, req_valid}, 64'd0);
  endtask

  task automatic consume(input int stall, input logic [31:0] exp_inst, input logic [63:0] exp_pc,
                         input string nm);
    for (int s = 0; s < stall; s++) begin
      tick();
      chk({nm, "_stall_valid"}, {63'd0, inst_valid}, 64'd1);
      chk({nm, "_stall_inst"}, {32'd0, inst_o}, {32'd0, exp_inst});
      chk({nm, "_stall_pc"}, pc_o, exp_pc);
      chk({nm, "_stall_no_req"}, {63'd0, req_valid}, 64'd0);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  initial begin
    logic        out;
    logic        busy;
    int          cnt;
    logic [63:0] pend;
    logic [63:0] mpc;
    int          idle;
    int          delivered;

    vecs[0] = '{k: 1, stall: 0, data: 32'h0000_0413, exp_pc: 64'h8000_0000};
    vecs[1] = '{k: 3, stall: 5, data: 32'h0010_0093, exp_pc: 64'h8000_0004};
    vecs[2] = '{k: 2, stall: 1, data: 32'hA5A5_1234, exp_pc: 64'h8000_0008};
    vecs[3] = '{k: 1, stall: 0, data: 32'h0000_006F, exp_pc: 64'h8000_000C};

    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_data      = '0;
    inst_ready     = 1'b0;

    #2 rst = 1'b0;
    #2;
    chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
    chk("rst_req_addr", req_addr, 64'h8000_0000);
    chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_inst", {32'd0, inst_o}, 64'd0);
    chk("rst_pc_o", pc_o, 64'd0);
    repeat (3) tick();
    rst = 1'b1;

    // Sequential fetches with varied response latency and decode stalls.
    for (int i = 0; i < 4; i++) begin
      issue_req(vecs[i].exp_pc, $sformatf("vec%0d", i));
      give_resp(vecs[i].k, vecs[i].data);
      check_full(vecs[i].data, vecs[i].exp_pc, $sformatf("vec%0d", i));
      consume(vecs[i].stall, vecs[i].data, vecs[i].exp_pc, $sformatf("vec%0d", i));
    end

    // Redirect while waiting: the response that follows must be discarded.
    issue_req(64'h8000_0010, "wait_redir");
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1000;
    tick();
    redirect_valid = 1'b0;
    give_resp(1, 32'hDEAD_BEEF);
    chk("wait_redir_no_inst", {63'd0, inst_valid}, 64'd0);
    wait_req(64'h8000_1000, "wait_redir_next");
    issue_req(64'h8000_1000, "after_redir");
    give_resp(2, 32'h1111_1111);
    check_full(32'h1111_1111, 64'h8000_1000, "after_redir");
    consume(0, 32'h1111_1111, 64'h8000_1000, "after_redir");

    // Redirect in the same cycle the request is accepted.
    wait_req(64'h8000_1004, "req_redir");
    req_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2000;
    tick();
    req_ready      = 1'b0;
    redirect_valid = 1'b0;
    give_resp(1, 32'hBAD0_BAD0);
    chk("req_redir_no_inst", {63'd0, inst_valid}, 64'd0);
    wait_req(64'h8000_2000, "req_redir_next");

    // Redirect beats a coincident decode accept in FULL.
    issue_req(64'h8000_2000, "full_redir");
    give_resp(1, 32'h2222_2222);
    check_full(32'h2222_2222, 64'h8000_2000, "full_redir");
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    inst_ready     = 1'b1;
    tick();
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    chk("full_redir_inst_valid", {63'd0, inst_valid}, 64'd0);
    wait_req(64'h8000_0100, "full_redir_next");

    // Reset in the middle of WAIT; a late response during reset is ignored.
    issue_req(64'h8000_0100, "mid_rst");
    rst = 1'b0;
    #1;
    chk("mid_rst_req_valid", {63'd0, req_valid}, 64'd0);
    chk("mid_rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("mid_rst_inst", {32'd0, inst_o}, 64'd0);
    chk("mid_rst_pc_o", pc_o, 64'd0);
    chk("mid_rst_addr", req_addr, 64'h8000_0000);
    tick();
    resp_valid = 1'b1;
    resp_data  = 32'h3333_3333;
    tick();
    resp_valid = 1'b0;
    tick();
    chk("mid_rst_late_resp", {63'd0, inst_valid}, 64'd0);
    rst = 1'b1;
    issue_req(64'h8000_0000, "post_rst");
    give_resp(1, 32'h0000_0413);
    check_full(32'h0000_0413, 64'h8000_0000, "post_rst");
    consume(0, 32'h0000_0413, 64'h8000_0000, "post_rst");

    // PC wrap and redirect-target alignment.
    wait_req(64'h8000_0004, "wrap_pre");
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    issue_req(64'hFFFF_FFFF_FFFF_FFFC, "wrap");
    give_resp(1, 32'h4444_4444);
    check_full(32'h4444_4444, 64'hFFFF_FFFF_FFFF_FFFC, "wrap");
    consume(0, 32'h4444_4444, 64'hFFFF_FFFF_FFFF_FFFC, "wrap");
    wait_req(64'h0, "wrap_next");
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0003;
    tick();
    redirect_valid = 1'b0;
    issue_req(64'h8000_0000, "align");
    give_resp(1, 32'h5555_5555);
    check_full(32'h5555_5555, 64'h8000_0000, "align");
    consume(0, 32'h5555_5555, 64'h8000_0000, "align");

    // Random run against a program-order model: every delivered instruction
    // must be the memory word at the architectural PC, which advances by 4
    // on each accept and jumps (aligned) on each redirect.
    out       = 1'b0;
    cnt       = 0;
    pend      = '0;
    mpc       = 64'h8000_0004;
    idle      = 0;
    delivered = 0;
    for (int c = 0; c < 4000; c++) begin
      resp_valid = 1'b0;
      busy       = out;
      if (out) begin
        cnt--;
        if (cnt == 0) begin
          resp_valid = 1'b1;
          resp_data  = mem_fn(pend);
          out        = 1'b0;
        end
      end
      req_ready      = ($urandom_range(0, 2) != 0);
      inst_ready     = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = {$urandom, $urandom};
      if (req_valid && req_ready) begin
        chk("rnd_single_outstanding", {63'd0, busy}, 64'd0);
        out  = 1'b1;
        cnt  = $urandom_range(1, 4);
        pend = req_addr;
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
        chk("rnd_pc", pc_o, mpc);
        chk("rnd_inst", {32'd0, inst_o}, {32'd0, mem_fn(mpc)});
        mpc = mpc + 64'd4;
        delivered++;
        idle = 0;
      end else begin
        idle++;
      end
      if (redirect_valid) mpc = {redirect_pc[63:2], 2'b00};
      if (idle > 300) begin
        checks++;
        failures++;
        $display("FAIL rnd_progress no delivery for %0d cycles, required at most 300", idle);
        break;
      end
      tick();
    end
    resp_valid     = 1'b0;
    req_ready      = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    chk("rnd_deliveries", {63'd0, delivered > 100}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
